// File: rtl/lm_555_timer_prog.sv
// Programmable 555-style pulse generator, astable or monostable.
// Phase lengths are computed from the R1/R2/C values with the 555 equations.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous reset, active-low
//   en       run enable; low forces IDLE at the next edge
//   mode     0 = astable, 1 = monostable (sampled when leaving IDLE)
//   trig     monostable trigger, level-sampled
//   cfg_load latch r1_in/r2_in/cap_in and recompute phase lengths
//   r1_in    R1 value
//   r2_in    R2 value
//   cap_in   C value
//   out      timer output, high while in HIGH (registered)
//   busy     high while not IDLE (registered)
//   cfg_sat  last computed length saturated to all-ones
module lm_555_timer_prog #(
    parameter int RW     = 8,
    parameter int CW     = 8,
    parameter int CNT_W  = 20,
    parameter int R1_DEF = 1,
    parameter int R2_DEF = 1,
    parameter int C_DEF  = 10,
    parameter int RETRIG = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          mode,
    input  logic          trig,
    input  logic          cfg_load,
    input  logic [RW-1:0] r1_in,
    input  logic [RW-1:0] r2_in,
    input  logic [CW-1:0] cap_in,
    output logic          out,
    output logic          busy,
    output logic          cfg_sat
);

    localparam int MW = RW + 1 + CW + 10;

    typedef logic [MW-1:0] mw_t;
    typedef logic [CNT_W-1:0] len_t;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    // Rounded 0.693*R*C in full precision, before clamping.
    function automatic mw_t raw_len(input logic [RW:0] rsum,
                                    input logic [CW-1:0] c);
        mw_t p;
        p = mw_t'(rsum) * mw_t'(c) * mw_t'(693) + mw_t'(500);
        return p / mw_t'(1000);
    endfunction

    function automatic logic is_sat(input mw_t q);
        return (q >> CNT_W) != '0;
    endfunction

    // Clamped to [1, 2^CNT_W-1].
    function automatic len_t clamp_len(input mw_t q);
        if (is_sat(q))
            return '1;
        else if (q == '0)
            return len_t'(1);
        else
            return q[CNT_W-1:0];
    endfunction

    logic [RW:0] hsum_new;
    logic [RW:0] lsum_new;
    logic [RW:0] hsum_def;
    logic [RW:0] lsum_def;
    mw_t         hq_new;
    mw_t         lq_new;
    mw_t         hq_def;
    mw_t         lq_def;

    assign hsum_new = {1'b0, r1_in} + {1'b0, r2_in};
    assign lsum_new = {1'b0, r2_in};
    assign hsum_def = (RW+1)'(R1_DEF) + (RW+1)'(R2_DEF);
    assign lsum_def = (RW+1)'(R2_DEF);

    assign hq_new = raw_len(hsum_new, cap_in);
    assign lq_new = raw_len(lsum_new, cap_in);
    assign hq_def = raw_len(hsum_def, CW'(C_DEF));
    assign lq_def = raw_len(lsum_def, CW'(C_DEF));

    state_t state;
    state_t state_n;
    len_t   cnt;
    len_t   cnt_n;
    len_t   hi_len;
    len_t   lo_len;
    logic   mode_q;
    logic   mode_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mode_n  = mode_q;
        if (!en) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!mode || trig) begin
                        state_n = HIGH;
                        cnt_n   = hi_len - 1'b1;
                        mode_n  = mode;
                    end
                end
                HIGH: begin
                    // A retrigger wins even on the final cycle.
                    if ((RETRIG != 0) && mode_q && trig) begin
                        cnt_n = hi_len - 1'b1;
                    end else if (cnt == '0) begin
                        if (mode_q) begin
                            state_n = IDLE;
                            cnt_n   = '0;
                        end else begin
                            state_n = LOW;
                            cnt_n   = lo_len - 1'b1;
                        end
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                LOW: begin
                    if (cnt == '0) begin
                        state_n = HIGH;
                        cnt_n   = hi_len - 1'b1;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            mode_q  <= 1'b0;
            out     <= 1'b0;
            busy    <= 1'b0;
            hi_len  <= clamp_len(hq_def);
            lo_len  <= clamp_len(lq_def);
            cfg_sat <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            mode_q <= mode_n;
            out    <= (state_n == HIGH);
            busy   <= (state_n != IDLE);
            // Running phase keeps its loaded count; new lengths
            // apply at the next phase entry.
            if (cfg_load) begin
                hi_len  <= clamp_len(hq_new);
                lo_len  <= clamp_len(lq_new);
                cfg_sat <= is_sat(hq_new) | is_sat(lq_new);
            end
        end
    end

endmodule

// File: tb/tb_lm_555_timer_prog.sv
// Bench for lm_555_timer_prog: phase-length scoreboard,
// config vector table, monostable and reset/enable sequences.
module tb_lm_555_timer_prog;

    localparam int LIM = 70000;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode;
    logic       trig;
    logic       cfg_load;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] cap;
    logic       out0, busy0, sat0;
    logic       out1, busy1, sat1;
    logic       sel;

    always #5 clk = ~clk;

    lm_555_timer_prog #(.CNT_W(16), .RETRIG(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .trig(trig),
        .cfg_load(cfg_load), .r1_in(r1), .r2_in(r2), .cap_in(cap),
        .out(out0), .busy(busy0), .cfg_sat(sat0)
    );

    lm_555_timer_prog #(.RETRIG(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .trig(trig),
        .cfg_load(cfg_load), .r1_in(r1), .r2_in(r2), .cap_in(cap),
        .out(out1), .busy(busy1), .cfg_sat(sat1)
    );

    wire ov = sel ? out1 : out0;
    wire bv = sel ? busy1 : busy0;

    typedef struct {
        logic lvl;
        int   len;
    } seg_t;

    typedef struct {
        logic [7:0] r1;
        logic [7:0] r2;
        logic [7:0] c;
        logic       mono;
        int         hi;
        int         lo;
        logic       sat;
    } vec_t;

    seg_t expq[$];
    vec_t tv[8];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic push(input logic lvl, input int len);
        seg_t e;
        e.lvl = lvl;
        e.len = len;
        expq.push_back(e);
    endtask

    // Count consecutive negedge samples at level lvl (bounded).
    task automatic seg(input logic lvl, output int n);
        n = 0;
        while (ov === lvl && n < LIM) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic drain(input string nm);
        seg_t e;
        int   n;
        int   k;
        k = 0;
        while (expq.size() > 0) begin
            e = expq.pop_front();
            seg(e.lvl, n);
            chk($sformatf("%s_seg%0d_lvl%0b", nm, k, e.lvl), n, e.len);
            k++;
        end
    endtask

    // Count a monostable pulse; pulse trig on high sample 'at'.
    task automatic mono(input int at, output int n, output int bb);
        n  = 0;
        bb = 0;
        while (ov === 1'b1 && n < LIM) begin
            n++;
            if (bv !== 1'b1) bb++;
            trig = (n == at);
            @(negedge clk);
        end
        trig = 1'b0;
    endtask

    initial begin
        int n;
        int bb;

        tv[0] = '{8'd1,   8'd1,   8'd10,  1'b0, 14,    7,  1'b0};
        tv[1] = '{8'd2,   8'd3,   8'd5,   1'b0, 17,    10, 1'b0};
        tv[2] = '{8'd4,   8'd0,   8'd7,   1'b0, 19,    1,  1'b0};
        tv[3] = '{8'd1,   8'd1,   8'd1,   1'b0, 1,     1,  1'b0};
        tv[4] = '{8'd0,   8'd1,   8'd3,   1'b0, 2,     2,  1'b0};
        tv[5] = '{8'd255, 8'd255, 8'd255, 1'b1, 65535, 0,  1'b1};
        tv[6] = '{8'd0,   8'd0,   8'd0,   1'b0, 1,     1,  1'b0};
        tv[7] = '{8'd255, 8'd255, 8'd0,   1'b0, 1,     1,  1'b0};

        sel      = 1'b0;
        rst      = 1'b0;
        en       = 1'b0;
        mode     = 1'b0;
        trig     = 1'b0;
        cfg_load = 1'b0;
        r1       = '0;
        r2       = '0;
        cap      = '0;

        #12;
        chkb("rst_out", out0, 1'b0);
        chkb("rst_busy", busy0, 1'b0);
        chkb("rst_sat", sat0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Astable with reset defaults: 14 high / 7 low.
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            push(1'b1, 14);
            push(1'b0, 7);
        end
        drain("t1");

        // Reconfigure during the first HIGH cycle.
        cfg_load = 1'b1;
        r1 = 8'd1;
        r2 = 8'd10;
        cap = 8'd10;
        @(negedge clk);
        cfg_load = 1'b0;
        seg(1'b1, n);
        chk("t2_hi_old", n + 1, 14);
        push(1'b0, 69);
        push(1'b1, 76);
        push(1'b0, 69);
        drain("t2");

        // en dropped mid-LOW, then restart.
        seg(1'b1, n);
        chk("t6_hi", n, 76);
        @(negedge clk);
        chkb("t6_busy_low", bv, 1'b1);
        en = 1'b0;
        @(negedge clk);
        chkb("t6_en_busy", bv, 1'b0);
        chkb("t6_en_out", ov, 1'b0);
        en = 1'b1;
        @(negedge clk);
        push(1'b1, 76);
        push(1'b0, 69);
        drain("t6_en");

        // Async reset mid-LOW restores defaults.
        seg(1'b1, n);
        chk("t6_hi2", n, 76);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chkb("t6_rst_busy", bv, 1'b0);
        chkb("t6_rst_out", ov, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push(1'b1, 14);
        push(1'b0, 7);
        drain("t6_rst");

        // Monostable, non-retriggerable.
        en   = 1'b0;
        mode = 1'b1;
        @(negedge clk);
        en   = 1'b1;
        trig = 1'b1;
        @(negedge clk);
        mono(5, n, bb);
        chk("t3_len", n, 14);
        chk("t3_busy", bb, 0);
        chkb("t3_idle_busy", bv, 1'b0);
        @(negedge clk);
        chkb("t3_stay_idle", ov, 1'b0);

        // Held trig: one low cycle between pulses.
        trig = 1'b1;
        @(negedge clk);
        push(1'b1, 14);
        push(1'b0, 1);
        push(1'b1, 14);
        drain("t3_hold");
        trig = 1'b0;

        // Retriggerable instance.
        en = 1'b0;
        @(negedge clk);
        sel  = 1'b1;
        en   = 1'b1;
        trig = 1'b1;
        @(negedge clk);
        mono(10, n, bb);
        chk("t4_len", n, 24);
        chk("t4_busy", bb, 0);
        sel = 1'b0;

        // Config table; en=0 and cfg_load share a cycle.
        for (int i = 0; i < 8; i++) begin
            en       = 1'b0;
            cfg_load = 1'b1;
            r1       = tv[i].r1;
            r2       = tv[i].r2;
            cap      = tv[i].c;
            mode     = tv[i].mono;
            @(negedge clk);
            cfg_load = 1'b0;
            chkb($sformatf("v%0d_idle_out", i), ov, 1'b0);
            chkb($sformatf("v%0d_idle_busy", i), bv, 1'b0);
            chkb($sformatf("v%0d_sat", i), sat0, tv[i].sat);
            en   = 1'b1;
            trig = tv[i].mono;
            @(negedge clk);
            trig = 1'b0;
            push(1'b1, tv[i].hi);
            if (!tv[i].mono) begin
                push(1'b0, tv[i].lo);
                push(1'b1, tv[i].hi);
            end
            drain($sformatf("v%0d", i));
        end

        en = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
